pe_store_sequencer: RTL and testbench

- Per-PE sequencer that drives the 6-bit local-store control bus {kernelCtrl[2:0], neuronCtrl[2:0]} and the shared 2-bit offset value.
- On each start it does four things in order: reset both address pointers, load the four row/column offsets, walk an R×C window, then report completion.
- Emits a per-element valid strobe with (row, col) indices, so the MAC stage knows when the kernel and neuron addresses are meaningful.
- Sits between the array-level scheduler (start/stall) and the local store address generators.

---
 rtl/pe_store_pkg.sv | 31 +++
 rtl/pe_scan_counter.sv | 42 ++++
 rtl/pe_store_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pe_store_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_store_pkg.sv
// Shared opcodes, FSM state encoding and control words for the PE local-store sequencer.
package pe_store_pkg;

    localparam logic [2:0] OP_INIT      = 3'b000;
    localparam logic [2:0] OP_HOLD      = 3'b001;
    localparam logic [2:0] OP_INCR      = 3'b010;
    localparam logic [2:0] OP_JUMP      = 3'b011;
    localparam logic [2:0] OP_SET_K_ROW = 3'b100;
    localparam logic [2:0] OP_SET_K_COL = 3'b101;
    localparam logic [2:0] OP_SET_N_ROW = 3'b110;
    localparam logic [2:0] OP_SET_N_COL = 3'b111;

    localparam logic [5:0] CTRL_IDLE = 6'b001001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SKR,
        S_SKC,
        S_SNR,
        S_SNC,
        S_SCAN,
        S_DONE
    } state_t;

    // Kernel and neuron halves always carry the same opcode.
    function automatic logic [5:0] ctrl_word(input logic [2:0] op);
        return {op, op};
    endfunction

endpackage

// File: rtl/pe_scan_counter.sv
// R x C row/column element counter with clear/advance and last-column/last-element flags.
module pe_scan_counter #(
    parameter int unsigned A = 7
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_advance,
    input  logic [A-1:0] i_rows,
    input  logic [A-1:0] i_cols,
    output logic [A-1:0] o_row,
    output logic [A-1:0] o_col,
    output logic         o_last_col,
    output logic         o_last_elem
);

    logic [A-1:0] r_row;
    logic [A-1:0] r_col;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (o_last_col) begin
                r_col <= '0;
                r_row <= r_row + A'(1);
            end else begin
                r_col <= r_col + A'(1);
            end
        end
    end

    assign o_row       = r_row;
    assign o_col       = r_col;
    assign o_last_col  = (r_col == i_cols - A'(1));
    assign o_last_elem = o_last_col && (r_row == i_rows - A'(1));

endmodule

// File: rtl/pe_store_sequencer.sv
// Per-PE local-store sequencer: pointer init, offset load, R x C window scan, done.
// Optional stallCycles counter enabled by defining PE_SEQ_STALL_CNT_EN.
module pe_store_sequencer
    import pe_store_pkg::*;
#(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    input  logic             stall,
    input  logic [A-1:0]     numRows,
    input  logic [A-1:0]     numCols,
    input  logic [depth-1:0] kRowOff,
    input  logic [depth-1:0] kColOff,
    input  logic [depth-1:0] nRowOff,
    input  logic [depth-1:0] nColOff,
    output logic [5:0]       controlSignal,
    output logic [depth-1:0] initSettings,
    output logic             busy,
    output logic             done,
    output logic             macValid,
    output logic [A-1:0]     rowIdx,
    output logic [A-1:0]     colIdx
`ifdef PE_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      stallCycles
`endif
);

    state_t           r_state;
    logic [A-1:0]     r_rows;
    logic [A-1:0]     r_cols;
    logic [depth-1:0] r_k_row_off;
    logic [depth-1:0] r_k_col_off;
    logic [depth-1:0] r_n_row_off;
    logic [depth-1:0] r_n_col_off;

    logic             w_clear;
    logic             w_advance;
    logic             w_last_col;
    logic             w_last_elem;
    logic [A-1:0]     w_row;
    logic [A-1:0]     w_col;

    // Counter is cleared on the SNC edge so element (0,0) appears with the first SCAN cycle.
    assign w_clear   = (r_state == S_SNC);
    assign w_advance = (r_state == S_SCAN) && !stall && !w_last_elem;

    pe_scan_counter #(
        .A(A)
    ) u_scan (
        .i_clk       (CLK),
        .i_rst_n     (RSTN),
        .i_clear     (w_clear),
        .i_advance   (w_advance),
        .i_rows      (r_rows),
        .i_cols      (r_cols),
        .o_row       (w_row),
        .o_col       (w_col),
        .o_last_col  (w_last_col),
        .o_last_elem (w_last_elem)
    );

    assign rowIdx = w_row;
    assign colIdx = w_col;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state       <= S_IDLE;
            controlSignal <= CTRL_IDLE;
            initSettings  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            macValid      <= 1'b0;
            r_rows        <= '0;
            r_cols        <= '0;
            r_k_row_off   <= '0;
            r_k_col_off   <= '0;
            r_n_row_off   <= '0;
            r_n_col_off   <= '0;
        end else begin
            controlSignal <= CTRL_IDLE;
            initSettings  <= '0;
            done          <= 1'b0;
            macValid      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rows        <= numRows;
                        r_cols        <= numCols;
                        r_k_row_off   <= kRowOff;
                        r_k_col_off   <= kColOff;
                        r_n_row_off   <= nRowOff;
                        r_n_col_off   <= nColOff;
                        busy          <= 1'b1;
                        controlSignal <= ctrl_word(OP_INIT);
                        r_state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    controlSignal <= ctrl_word(OP_SET_K_ROW);
                    initSettings  <= r_k_row_off;
                    r_state       <= S_SKR;
                end
                S_SKR: begin
                    controlSignal <= ctrl_word(OP_SET_K_COL);
                    initSettings  <= r_k_col_off;
                    r_state       <= S_SKC;
                end
                S_SKC: begin
                    controlSignal <= ctrl_word(OP_SET_N_ROW);
                    initSettings  <= r_n_row_off;
                    r_state       <= S_SNR;
                end
                S_SNR: begin
                    controlSignal <= ctrl_word(OP_SET_N_COL);
                    initSettings  <= r_n_col_off;
                    r_state       <= S_SNC;
                end
                S_SNC: begin
                    if (r_rows != '0 && r_cols != '0) begin
                        macValid <= 1'b1;
                        r_state  <= S_SCAN;
                    end else begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_SCAN: begin
                    // Outputs describe the element the pointers reach at the next falling edge.
                    if (!stall) begin
                        if (w_last_elem) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            macValid      <= 1'b1;
                            controlSignal <= ctrl_word(w_last_col ? OP_JUMP : OP_INCR);
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PE_SEQ_STALL_CNT_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stallCycles <= '0;
        end else if (r_state == S_IDLE && start) begin
            stallCycles <= '0;
        end else if (r_state == S_SCAN && stall && stallCycles != 16'hFFFF) begin
            stallCycles <= stallCycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_store_sequencer.sv
// Self-checking bench for pe_store_sequencer: directed scenarios plus randomized traffic
// against a queue/arithmetic reference model. Honours PE_SEQ_STALL_CNT_EN.
`timescale 1ns/1ps
module tb_pe_store_sequencer;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned AW     = 7;
    localparam logic [5:0]  W_HOLD = 6'b001001;
    localparam logic [5:0]  W_INCR = 6'b010010;
    localparam logic [5:0]  W_JUMP = 6'b011011;
    localparam logic [5:0]  W_INIT = 6'b000000;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             start;
    logic             stall;
    logic [AW-1:0]    numRows;
    logic [AW-1:0]    numCols;
    logic [DEPTH-1:0] kRowOff;
    logic [DEPTH-1:0] kColOff;
    logic [DEPTH-1:0] nRowOff;
    logic [DEPTH-1:0] nColOff;
    logic [5:0]       controlSignal;
    logic [DEPTH-1:0] initSettings;
    logic             busy;
    logic             done;
    logic             macValid;
    logic [AW-1:0]    rowIdx;
    logic [AW-1:0]    colIdx;
`ifdef PE_SEQ_STALL_CNT_EN
    logic [15:0]      stallCycles;
`endif

    pe_store_sequencer #(
        .depth(DEPTH),
        .A    (AW)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .start        (start),
        .stall        (stall),
        .numRows      (numRows),
        .numCols      (numCols),
        .kRowOff      (kRowOff),
        .kColOff      (kColOff),
        .nRowOff      (nRowOff),
        .nColOff      (nColOff),
        .controlSignal(controlSignal),
        .initSettings (initSettings),
        .busy         (busy),
        .done         (done),
        .macValid     (macValid),
        .rowIdx       (rowIdx),
        .colIdx       (colIdx)
`ifdef PE_SEQ_STALL_CNT_EN
        ,
        .stallCycles  (stallCycles)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned done_at  = 0;

    // Reference model: pending setup words, element index n within the R x C window.
    bit           m_active;
    bit           m_done_shown;
    logic [4:0]   m_setup_q[$];
    int unsigned  m_R;
    int unsigned  m_C;
    int unsigned  m_n;

    logic [5:0]   e_ctrl;
    logic [1:0]   e_init;
    bit           e_init_chk;
    bit           e_busy;
    bit           e_done;
    bit           e_mv;
    int unsigned  e_row;
    int unsigned  e_col;
    logic [15:0]  e_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active     = 1'b0;
        m_done_shown = 1'b0;
        m_setup_q.delete();
        m_R = 0; m_C = 0; m_n = 0;
        e_ctrl = W_HOLD; e_init = '0; e_init_chk = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_mv = 1'b0;
        e_row = 0; e_col = 0; e_stall = '0;
    endtask

    // Predict outputs after the coming rising edge from the inputs currently driven.
    task automatic model_edge();
        logic [4:0]  w;
        int unsigned total;
        e_done     = 1'b0;
        e_mv       = 1'b0;
        e_ctrl     = W_HOLD;
        e_init_chk = 1'b0;
        total      = m_R * m_C;
        if (m_done_shown) begin
            m_done_shown = 1'b0;
            m_active     = 1'b0;
            e_busy       = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                e_busy   = 1'b1;
                e_ctrl   = W_INIT;
                m_R      = numRows;
                m_C      = numCols;
                m_n      = 0;
                e_stall  = '0;
                m_setup_q.delete();
                m_setup_q.push_back({3'b100, kRowOff});
                m_setup_q.push_back({3'b101, kColOff});
                m_setup_q.push_back({3'b110, nRowOff});
                m_setup_q.push_back({3'b111, nColOff});
            end
        end else if (m_setup_q.size() != 0) begin
            w          = m_setup_q.pop_front();
            e_ctrl     = {w[4:2], w[4:2]};
            e_init     = w[1:0];
            e_init_chk = 1'b1;
        end else if (m_n < total && (m_n == 0 || !stall)) begin
            e_row  = m_n / m_C;
            e_col  = m_n % m_C;
            e_ctrl = (m_n == 0) ? W_HOLD : ((e_col == 0) ? W_JUMP : W_INCR);
            e_mv   = 1'b1;
            m_n++;
        end else if (stall && m_n != 0) begin
            if (e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
        end else begin
            e_done       = 1'b1;
            m_done_shown = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        check_eq("ctrl", 32'(controlSignal), 32'(e_ctrl));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("macValid", 32'(macValid), 32'(e_mv));
        if (e_mv) begin
            check_eq("rowIdx", 32'(rowIdx), e_row);
            check_eq("colIdx", 32'(colIdx), e_col);
        end
        if (e_init_chk) check_eq("initSettings", 32'(initSettings), 32'(e_init));
`ifdef PE_SEQ_STALL_CNT_EN
        check_eq("stallCycles", 32'(stallCycles), 32'(e_stall));
`endif
        if (done === 1'b1) done_at = cyc;
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic start_op(input int unsigned r, input int unsigned c,
                            input logic [1:0] kr, input logic [1:0] kc,
                            input logic [1:0] nr, input logic [1:0] nc);
        numRows = AW'(r); numCols = AW'(c);
        kRowOff = kr; kColOff = kc; nRowOff = nr; nColOff = nc;
        stall   = 1'b0;
        start   = 1'b1;
        cyc     = 0;
        done_at = 0;
        step();
        start   = 1'b0;
    endtask

    task automatic run_until_idle(input int unsigned budget);
        int unsigned k = 0;
        while (m_active && k < budget) begin
            step();
            k++;
        end
        check_eq("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        RSTN = 1'b0; start = 1'b0; stall = 1'b0;
        numRows = '0; numCols = '0;
        kRowOff = '0; kColOff = '0; nRowOff = '0; nColOff = '0;
        model_reset();

        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_ctrl", 32'(controlSignal), 32'(W_HOLD));
        check_eq("rst_init", 32'(initSettings), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mv", 32'(macValid), 32'd0);
        check_eq("rst_row", 32'(rowIdx), 32'd0);
        check_eq("rst_col", 32'(colIdx), 32'd0);
        RSTN = 1'b1;
        repeat (3) step();

        // Setup sequence and full scan, R=2 C=3.
        start_op(2, 3, 2'd1, 2'd2, 2'd3, 2'd0);
        run_until_idle(100);
        check_eq("done_at_2x3", done_at, 32'd12);

        // Three stall cycles at element (0,1).
        start_op(2, 3, 2'd1, 2'd2, 2'd3, 2'd0);
        while (cyc < 7) step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        run_until_idle(100);
        check_eq("done_at_stall", done_at, 32'd15);
`ifdef PE_SEQ_STALL_CNT_EN
        check_eq("stall_cnt_3", 32'(stallCycles), 32'd3);
`endif

        // Degenerate window.
        start_op(0, 5, 2'd3, 2'd1, 2'd2, 2'd0);
        run_until_idle(100);
        check_eq("done_at_r0", done_at, 32'd6);

        // Start pulses during SCAN and during DONE are ignored.
        start_op(3, 2, 2'd2, 2'd1, 2'd0, 2'd3);
        while (cyc < 7) step();
        numRows = AW'(5); numCols = AW'(1);
        kRowOff = 2'd0; kColOff = 2'd3; nRowOff = 2'd1; nColOff = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int unsigned k = 0;
            while (done !== 1'b1 && k < 50) begin
                step();
                k++;
            end
            check_eq("busy_done_seen", 32'(done), 32'd1);
        end
        check_eq("done_at_3x2", done_at, 32'd12);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();

        // Asynchronous reset in the middle of a scan.
        start_op(4, 4, 2'd1, 2'd1, 2'd1, 2'd1);
        repeat (8) step();
        #2;
        RSTN = 1'b0;
        #1;
        check_eq("arst_ctrl", 32'(controlSignal), 32'(W_HOLD));
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_mv", 32'(macValid), 32'd0);
        check_eq("arst_row", 32'(rowIdx), 32'd0);
        check_eq("arst_col", 32'(colIdx), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        repeat (4) step();

        // Randomized traffic: random start/stall pulses and window sizes.
        for (int i = 0; i < 800; i++) begin
            start   = ($urandom_range(0, 5) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            numRows = AW'($urandom_range(0, 4));
            numCols = AW'($urandom_range(0, 4));
            kRowOff = DEPTH'($urandom);
            kColOff = DEPTH'($urandom);
            nRowOff = DEPTH'($urandom);
            nColOff = DEPTH'($urandom);
            step();
        end
        start = 1'b0;
        stall = 1'b0;
        run_until_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
